// File: rtl/uart_xcvr.sv
// uart_xcvr: parametrised UART transceiver with a buffered, error-tagged receive FIFO.
// Optional feature macro UART_XCVR_LOOPBACK_EN adds a `loopback` port routing TxD into the receiver.
//
// state   | meaning (shared by the TX and RX FSMs)
// S_IDLE  | line idle; TX waits for tx_valid, RX waits for a start edge
// S_START | start bit (RX: half-bit wait then start re-check)
// S_DATA  | DW data bits, LSB first
// S_PAR   | parity bit (never entered when PARITY = "NONE")
// S_STOP  | stop bit(s); RX samples only the first
module uart_xcvr #(
    parameter int    DW       = 8,
    parameter int    SW       = 1,
    parameter string PARITY   = "NONE",
    parameter logic  IDLE     = 1'b1,
    parameter int    DIV      = 16,
    parameter int    RX_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tx_valid,
    input  logic [DW-1:0] tx_data,
    output logic          tx_ready,
    output logic          rx_valid,
    output logic [DW-1:0] rx_data,
    output logic          rx_perr,
    output logic          rx_ferr,
    input  logic          rx_ready,
    output logic          rx_ovf,
`ifdef UART_XCVR_LOOPBACK_EN
    input  logic          loopback,
`endif
    output logic          TxD,
    input  logic          RxD
);

    localparam bit HAS_PAR = (PARITY != "NONE");
    localparam bit ODD_PAR = (PARITY == "ODD");
    localparam int CW      = $clog2(DIV);
    localparam int BW      = $clog2(DW);
    localparam int AW      = $clog2(RX_DEPTH);

    localparam logic [CW-1:0] CNT_BIT   = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(DIV / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DW - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(SW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------ transmit
    state_t        tx_state, tx_state_nxt;
    logic [CW-1:0] tx_cnt, tx_cnt_nxt;
    logic [BW-1:0] tx_bits, tx_bits_nxt;
    logic [DW-1:0] tx_shift, tx_shift_nxt;
    logic          tx_par, tx_par_nxt;
    logic          tx_line, tx_line_nxt;
    logic          tx_tc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bits  <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_line  <= IDLE;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bits  <= tx_bits_nxt;
            tx_shift <= tx_shift_nxt;
            tx_par   <= tx_par_nxt;
            tx_line  <= tx_line_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_bits_nxt  = tx_bits;
        tx_shift_nxt = tx_shift;
        tx_par_nxt   = tx_par;
        tx_line_nxt  = tx_line;
        tx_tc        = (tx_cnt == '0);
        tx_cnt_nxt   = tx_tc ? tx_cnt : tx_cnt - CW'(1);
        // Ready during the final stop cycle so a held tx_valid chains frames with no gap.
        tx_ready     = (tx_state == S_IDLE) ||
                       ((tx_state == S_STOP) && tx_tc && (tx_bits == '0));

        unique case (tx_state)
            S_IDLE: ;
            S_START: begin
                if (tx_tc) begin
                    tx_state_nxt = S_DATA;
                    tx_cnt_nxt   = CNT_BIT;
                    tx_bits_nxt  = DATA_LAST;
                    tx_line_nxt  = tx_shift[0];
                end
            end
            S_DATA: begin
                if (tx_tc) begin
                    tx_cnt_nxt = CNT_BIT;
                    if (tx_bits == '0) begin
                        if (HAS_PAR) begin
                            tx_state_nxt = S_PAR;
                            tx_line_nxt  = tx_par;
                        end else begin
                            tx_state_nxt = S_STOP;
                            tx_bits_nxt  = STOP_LAST;
                            tx_line_nxt  = IDLE;
                        end
                    end else begin
                        tx_bits_nxt  = tx_bits - BW'(1);
                        tx_shift_nxt = tx_shift >> 1;
                        tx_line_nxt  = tx_shift[1];
                    end
                end
            end
            S_PAR: begin
                if (tx_tc) begin
                    tx_state_nxt = S_STOP;
                    tx_cnt_nxt   = CNT_BIT;
                    tx_bits_nxt  = STOP_LAST;
                    tx_line_nxt  = IDLE;
                end
            end
            S_STOP: begin
                if (tx_tc) begin
                    if (tx_bits == '0) begin
                        tx_state_nxt = S_IDLE;
                    end else begin
                        tx_bits_nxt = tx_bits - BW'(1);
                        tx_cnt_nxt  = CNT_BIT;
                    end
                end
            end
            default: tx_state_nxt = S_IDLE;
        endcase

        if (tx_valid && tx_ready) begin
            tx_state_nxt = S_START;
            tx_cnt_nxt   = CNT_BIT;
            tx_shift_nxt = tx_data;
            tx_par_nxt   = ODD_PAR ? ~^tx_data : ^tx_data;
            tx_line_nxt  = ~IDLE;
        end
    end

    // ------------------------------------------------------------------ line routing
    logic rx_src;

`ifdef UART_XCVR_LOOPBACK_EN
    assign rx_src = loopback ? tx_line : RxD;
    assign TxD    = loopback ? IDLE : tx_line;
`else
    assign rx_src = RxD;
    assign TxD    = tx_line;
`endif

    logic rx_meta, rxs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= IDLE;
            rxs     <= IDLE;
        end else begin
            rx_meta <= rx_src;
            rxs     <= rx_meta;
        end
    end

    // ------------------------------------------------------------------ receive
    state_t        rx_state, rx_state_nxt;
    logic [CW-1:0] rx_cnt, rx_cnt_nxt;
    logic [BW-1:0] rx_bits, rx_bits_nxt;
    logic [DW-1:0] rx_shift, rx_shift_nxt;
    logic          rx_pbit, rx_pbit_nxt;
    logic          rx_tc, rx_exp_par;
    logic          push, push_perr, push_ferr;

    assign rx_exp_par = ODD_PAR ? ~^rx_shift : ^rx_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
            rx_pbit  <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bits  <= rx_bits_nxt;
            rx_shift <= rx_shift_nxt;
            rx_pbit  <= rx_pbit_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_bits_nxt  = rx_bits;
        rx_shift_nxt = rx_shift;
        rx_pbit_nxt  = rx_pbit;
        push         = 1'b0;
        push_perr    = 1'b0;
        push_ferr    = 1'b0;
        rx_tc        = (rx_cnt == '0);
        rx_cnt_nxt   = rx_tc ? rx_cnt : rx_cnt - CW'(1);

        unique case (rx_state)
            S_IDLE: begin
                if (rxs != IDLE) begin
                    rx_state_nxt = S_START;
                    rx_cnt_nxt   = CNT_HALF;
                end
            end
            S_START: begin
                if (rx_tc) begin
                    if (rxs == IDLE) begin
                        rx_state_nxt = S_IDLE;
                    end else begin
                        rx_state_nxt = S_DATA;
                        rx_cnt_nxt   = CNT_BIT;
                        rx_bits_nxt  = DATA_LAST;
                    end
                end
            end
            S_DATA: begin
                if (rx_tc) begin
                    rx_shift_nxt = {rxs, rx_shift[DW-1:1]};
                    rx_cnt_nxt   = CNT_BIT;
                    if (rx_bits == '0) begin
                        rx_state_nxt = HAS_PAR ? S_PAR : S_STOP;
                    end else begin
                        rx_bits_nxt = rx_bits - BW'(1);
                    end
                end
            end
            S_PAR: begin
                if (rx_tc) begin
                    rx_pbit_nxt  = rxs;
                    rx_state_nxt = S_STOP;
                    rx_cnt_nxt   = CNT_BIT;
                end
            end
            S_STOP: begin
                // Back to IDLE at the stop-bit centre so a following start edge is not missed.
                if (rx_tc) begin
                    push         = 1'b1;
                    push_ferr    = (rxs != IDLE);
                    push_perr    = HAS_PAR && (rx_pbit != rx_exp_par);
                    rx_state_nxt = S_IDLE;
                end
            end
            default: rx_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------ receive FIFO
    logic [DW+1:0] mem [RX_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, pop, wr_en;

    assign rx_valid = (wr_ptr != rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = rx_valid && rx_ready;
    // A same-cycle pop frees the head slot, so a push into a full FIFO still lands.
    assign wr_en    = push && (!full || pop);

    assign {rx_perr, rx_ferr, rx_data} = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rx_ovf <= 1'b0;
            for (int i = 0; i < RX_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= {push_perr, push_ferr, rx_shift};
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            rx_ovf <= push && full && !pop;
        end
    end

endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench for uart_xcvr (DW=8, SW=1, EVEN parity, DIV=16, RX_DEPTH=4) with an RX scoreboard queue.
module tb_uart_xcvr;

    localparam int DW       = 8;
    localparam int DIV      = 16;
    localparam int RX_DEPTH = 4;
    localparam int FRAME    = (1 + DW + 1 + 1) * DIV;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_ready;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          rx_perr;
    logic          rx_ferr;
    logic          rx_ready = 1'b0;
    logic          rx_ovf;
    logic          txd;
    logic          rxd;
    logic          rxd_drv = 1'b1;
    logic          bench_loop = 1'b0;
`ifdef UART_XCVR_LOOPBACK_EN
    logic          loopback = 1'b0;
`endif

    assign rxd = bench_loop ? txd : rxd_drv;

    uart_xcvr #(
        .DW(DW), .SW(1), .PARITY("EVEN"), .IDLE(1'b1), .DIV(DIV), .RX_DEPTH(RX_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rx_perr(rx_perr),
        .rx_ferr(rx_ferr),
        .rx_ready(rx_ready),
        .rx_ovf(rx_ovf),
`ifdef UART_XCVR_LOOPBACK_EN
        .loopback(loopback),
`endif
        .TxD(txd),
        .RxD(rxd)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pop   = 0;
    int          ovf_cnt = 0;
    int unsigned cyc     = 0;
    logic [9:0]  exp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop side: every consumed head character is compared with the oldest expectation.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rx_ovf === 1'b1) ovf_cnt++;
        if (rst === 1'b0 && rx_valid === 1'b1 && rx_ready === 1'b1) begin
            n_pop++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'bx;
            check("rx_char", 32'({rx_perr, rx_ferr, rx_data}), 32'(e));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rx(input logic [7:0] d, input logic pbit, input logic sbit);
        exp_q.push_back({pbit != ^d, sbit != 1'b1, d});
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic pbit, input logic sbit);
        logic [10:0] bits;
        bits = {sbit, pbit, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rxd_drv = bits[i];
            repeat (DIV) tick();
        end
        rxd_drv = 1'b1;
    endtask

    task automatic tx_frame_check(input logic [7:0] d, input string tag);
        logic [10:0] bits;
        int          k;
        int          errs;
        int          rdy_at;
        bits     = {1'b1, ^d, d, 1'b0};
        tx_data  = d;
        tx_valid = 1'b1;
        k = 0;
        while (tx_ready !== 1'b1 && k < 400) begin
            tick();
            k++;
        end
        check({tag, "_accept"}, 32'(tx_ready), 32'd1);
        tick();
        tx_valid = 1'b0;
        tx_data  = ~d;
        errs     = 0;
        rdy_at   = 0;
        for (int c = 1; c <= FRAME; c++) begin
            if (txd !== bits[(c - 1) / DIV]) errs++;
            if (rdy_at == 0 && tx_ready === 1'b1) rdy_at = c;
            if (c < FRAME) tick();
        end
        tick();
        check({tag, "_bit_errors"}, 32'(errs), 32'd0);
        check({tag, "_ready_cycle"}, 32'(rdy_at), 32'(FRAME));
    endtask

    logic [7:0]  d8;
    logic [7:0]  stream [3];
    int unsigned acc_cyc [3];
    int          acc_n;
    int          pop0;
    int          txd_err;

    initial begin
        stream = '{8'h00, 8'hFF, 8'h80};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_tx_ready", 32'(tx_ready), 32'd1);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_ovf", 32'(rx_ovf), 32'd0);

        tx_frame_check(8'hA5, "tx_a5");

        // Parity error, framing error, then a short glitch that must not be taken as a start bit.
        rx_ready = 1'b1;
        pop0 = n_pop;
        expect_rx(8'h3C, 1'b1, 1'b1);
        rx_frame(8'h3C, 1'b1, 1'b1);
        expect_rx(8'h55, 1'b0, 1'b0);
        rx_frame(8'h55, 1'b0, 1'b0);
        repeat (20) tick();
        rxd_drv = 1'b0;
        repeat (4) tick();
        rxd_drv = 1'b1;
        repeat (40) tick();
        check("rx_err_pops", 32'(n_pop - pop0), 32'd2);
        check("glitch_no_write", 32'(rx_valid), 32'd0);

        // Overflow with a 4-entry FIFO.
        rx_ready = 1'b0;
        ovf_cnt  = 0;
        for (int i = 1; i <= 4; i++) begin
            d8 = 8'(i);
            expect_rx(d8, ^d8, 1'b1);
            rx_frame(d8, ^d8, 1'b1);
        end
        repeat (4) tick();
        check("ovf_none_when_filling", 32'(ovf_cnt), 32'd0);
        check("fifo_full_valid", 32'(rx_valid), 32'd1);
        rx_frame(8'h05, ^8'h05, 1'b1);
        repeat (4) tick();
        check("ovf_one_pulse", 32'(ovf_cnt), 32'd1);
        // Pop coincides with the push edge of this frame: it must land, not drop.
        expect_rx(8'h06, ^8'h06, 1'b1);
        fork
            rx_frame(8'h06, ^8'h06, 1'b1);
            begin
                repeat (2 + DIV / 2 + 10 * DIV) tick();
                rx_ready = 1'b1;
                tick();
                rx_ready = 1'b0;
            end
        join
        repeat (4) tick();
        check("ovf_push_pop_full", 32'(ovf_cnt), 32'd1);
        pop0 = n_pop;
        rx_ready = 1'b1;
        repeat (12) tick();
        check("drain_count", 32'(n_pop - pop0), 32'd4);
        check("drain_empty", 32'(rx_valid), 32'd0);
        check("drain_sb_empty", 32'(exp_q.size()), 32'd0);

        // Back-to-back frames looped from TX to RX.
`ifdef UART_XCVR_LOOPBACK_EN
        loopback = 1'b1;
`else
        bench_loop = 1'b1;
`endif
        pop0     = n_pop;
        acc_n    = 0;
        txd_err  = 0;
        tx_valid = 1'b1;
        tx_data  = stream[0];
        for (int k = 0; k < 1000 && acc_n < 3; k++) begin
`ifdef UART_XCVR_LOOPBACK_EN
            if (txd !== 1'b1) txd_err++;
`endif
            if (tx_ready === 1'b1) begin
                acc_cyc[acc_n] = cyc;
                expect_rx(stream[acc_n], ^stream[acc_n], 1'b1);
                acc_n++;
                tick();
                if (acc_n < 3) tx_data = stream[acc_n];
                else tx_valid = 1'b0;
            end else begin
                tick();
            end
        end
        tx_valid = 1'b0;
        check("b2b_accepts", 32'(acc_n), 32'd3);
        check("b2b_gap_0_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(FRAME));
        check("b2b_gap_1_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(FRAME));
        repeat (FRAME + 40) tick();
        check("b2b_rx_count", 32'(n_pop - pop0), 32'd3);
        check("b2b_sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef UART_XCVR_LOOPBACK_EN
        check("loopback_pin_idle", 32'(txd_err), 32'd0);
        loopback = 1'b0;
`else
        bench_loop = 1'b0;
`endif

        // Reset in the middle of a TX frame and an RX frame with two entries queued.
        rx_ready = 1'b0;
        expect_rx(8'h11, ^8'h11, 1'b1);
        rx_frame(8'h11, ^8'h11, 1'b1);
        expect_rx(8'h22, ^8'h22, 1'b1);
        rx_frame(8'h22, ^8'h22, 1'b1);
        check("pre_rst_queued", 32'(rx_valid), 32'd1);
        tx_data  = 8'h33;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        rxd_drv  = 1'b0;
        repeat (5 * DIV) tick();
        check("pre_rst_tx_busy", 32'(tx_ready), 32'd0);
        rst = 1'b1;
        #2;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        exp_q.delete();
        rxd_drv = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();

        bench_loop = 1'b1;
        rx_ready   = 1'b1;
        pop0       = n_pop;
        expect_rx(8'h5A, ^8'h5A, 1'b1);
        tx_frame_check(8'h5A, "tx_post_rst");
        repeat (30) tick();
        check("post_rst_rx_count", 32'(n_pop - pop0), 32'd1);
        check("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);
        bench_loop = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
